// File: rtl/uart_cmd_pkg.sv
// Shared constants, state encoding and helpers for the UART command decoder.
package uart_cmd_pkg;

  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_SP    = 8'h20;
  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_9     = 8'h39;
  localparam logic [7:0] ASCII_R     = 8'h52;
  localparam logic [7:0] ASCII_R_LC  = 8'h72;
  localparam logic [7:0] ASCII_C     = 8'h43;
  localparam logic [7:0] ASCII_C_LC  = 8'h63;
  localparam logic [7:0] ASCII_M     = 8'h4D;
  localparam logic [7:0] ASCII_M_LC  = 8'h6D;
  localparam logic [7:0] ASCII_S     = 8'h53;
  localparam logic [7:0] ASCII_S_LC  = 8'h73;

  localparam logic [6:0] HOUR_MAX = 7'd23;
  localparam logic [6:0] MIN_MAX  = 7'd59;
  localparam logic [6:0] SEC_MAX  = 7'd59;

  localparam int unsigned NUM_DIGITS = 6;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DIGITS   = 2'd1,
    ST_WAIT_END = 2'd2
  } state_t;

  // Two decimal digits to binary, shift-add instead of a multiplier.
  function automatic logic [6:0] dec2bin(input logic [3:0] tens, input logic [3:0] ones);
    logic [6:0] t;
    t = {3'b000, tens};
    return (t << 3) + (t << 1) + {3'b000, ones};
  endfunction

endpackage

// File: rtl/cmd_timeout_timer.sv
// Inter-byte watchdog: counts while enabled, expires on reaching TIMEOUT_CYC-1.
module cmd_timeout_timer #(
  parameter int unsigned TIMEOUT_CYC = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] cnt;

  // A received byte (clr) always wins over a coincident expiry.
  assign expire = en && !clr && (cnt == LAST);

  // Free-running count while armed; held at zero when idle or on a new byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           cnt <= '0;
    else if (clr || !en || cnt == LAST) cnt <= '0;
    else                               cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/uart_cmd_decoder.sv
// ASCII command decoder: single-char control pulses, "S hhmmss<CR>" time load,
// ACK/NAK response byte handed to the UART transmitter.
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 100_000_000,
  parameter logic [7:0]  ACK_CHAR    = 8'h4B,
  parameter logic [7:0]  NAK_CHAR    = 8'h45
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  input  logic       tx_busy,
  output logic       o_run,
  output logic       o_clear,
  output logic       o_mode,
  output logic       o_set_valid,
  output logic [4:0] o_set_hour,
  output logic [5:0] o_set_min,
  output logic [5:0] o_set_sec,
  output logic       o_err,
  output logic [7:0] o_tx_data,
  output logic       o_tx_start
);

  state_t state, state_n;
  logic [2:0] idx, idx_n;
  logic [NUM_DIGITS-1:0][3:0] digits;
  logic dig_we;
  logic run_n, clear_n, mode_n, set_n, err_n;
  logic q_n;
  logic [7:0] q_byte;
  logic ack_pending;
  logic expire;
  logic [6:0] hour_v, min_v, sec_v;
  logic time_ok;

  cmd_timeout_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (rx_done),
    .en     (state != ST_IDLE),
    .expire (expire)
  );

  assign hour_v  = dec2bin(digits[0], digits[1]);
  assign min_v   = dec2bin(digits[2], digits[3]);
  assign sec_v   = dec2bin(digits[4], digits[5]);
  assign time_ok = (hour_v <= HOUR_MAX) && (min_v <= MIN_MAX) && (sec_v <= SEC_MAX);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // Next state, next pulse values and response request for the current byte.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    dig_we  = 1'b0;
    run_n   = 1'b0;
    clear_n = 1'b0;
    mode_n  = 1'b0;
    set_n   = 1'b0;
    err_n   = 1'b0;
    q_n     = 1'b0;
    q_byte  = ACK_CHAR;
    case (state)
      ST_IDLE: begin
        if (rx_done) begin
          case (rx_data)
            ASCII_R, ASCII_R_LC: begin run_n   = 1'b1; q_n = 1'b1; end
            ASCII_C, ASCII_C_LC: begin clear_n = 1'b1; q_n = 1'b1; end
            ASCII_M, ASCII_M_LC: begin mode_n  = 1'b1; q_n = 1'b1; end
            ASCII_S, ASCII_S_LC: begin state_n = ST_DIGITS; idx_n = '0; end
            ASCII_CR, ASCII_LF, ASCII_SP: ;
            default: begin err_n = 1'b1; q_n = 1'b1; q_byte = NAK_CHAR; end
          endcase
        end
      end
      ST_DIGITS: begin
        if (rx_done) begin
          if (rx_data inside {[ASCII_0:ASCII_9]}) begin
            dig_we = 1'b1;
            idx_n  = idx + 3'd1;
            if (idx == 3'(NUM_DIGITS - 1)) state_n = ST_WAIT_END;
          end else if (rx_data == ASCII_SP) begin
            // spacing between fields is tolerated
          end else if (rx_data == ASCII_S || rx_data == ASCII_S_LC) begin
            idx_n = '0;
          end else begin
            err_n = 1'b1; q_n = 1'b1; q_byte = NAK_CHAR; state_n = ST_IDLE;
          end
        end else if (expire) begin
          err_n = 1'b1; q_n = 1'b1; q_byte = NAK_CHAR; state_n = ST_IDLE;
        end
      end
      ST_WAIT_END: begin
        if (rx_done) begin
          state_n = ST_IDLE;
          if ((rx_data == ASCII_CR || rx_data == ASCII_LF) && time_ok) begin
            set_n = 1'b1; q_n = 1'b1;
          end else begin
            err_n = 1'b1; q_n = 1'b1; q_byte = NAK_CHAR;
          end
        end else if (expire) begin
          err_n = 1'b1; q_n = 1'b1; q_byte = NAK_CHAR; state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Digit buffer and capture index; '0'..'9' are 0x30..0x39 so the low nibble is the value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx    <= '0;
      digits <= '0;
    end else begin
      idx <= idx_n;
      if (dig_we) digits[idx] <= rx_data[3:0];
    end
  end

  // Registered single-cycle command pulses and the held time-of-day.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_run       <= 1'b0;
      o_clear     <= 1'b0;
      o_mode      <= 1'b0;
      o_set_valid <= 1'b0;
      o_err       <= 1'b0;
      o_set_hour  <= '0;
      o_set_min   <= '0;
      o_set_sec   <= '0;
    end else begin
      o_run       <= run_n;
      o_clear     <= clear_n;
      o_mode      <= mode_n;
      o_set_valid <= set_n;
      o_err       <= err_n;
      if (set_n) begin
        o_set_hour <= hour_v[4:0];
        o_set_min  <= min_v[5:0];
        o_set_sec  <= sec_v[5:0];
      end
    end
  end

  // Response register: newest byte wins, start fires once the transmitter is free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_tx_data   <= '0;
      o_tx_start  <= 1'b0;
      ack_pending <= 1'b0;
    end else if (q_n) begin
      o_tx_data   <= q_byte;
      o_tx_start  <= 1'b0;
      ack_pending <= 1'b1;
    end else if (ack_pending && !tx_busy) begin
      o_tx_start  <= 1'b1;
      ack_pending <= 1'b0;
    end else begin
      o_tx_start  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Randomized and directed bench for uart_cmd_decoder against a queue-based command model.
module tb_uart_cmd_decoder;

  localparam int TO = 50;
  localparam logic [7:0] ACK = 8'h4B;
  localparam logic [7:0] NAK = 8'h45;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic       tx_busy = 1'b0;
  logic       o_run, o_clear, o_mode, o_set_valid, o_err, o_tx_start;
  logic [4:0] o_set_hour;
  logic [5:0] o_set_min, o_set_sec;
  logic [7:0] o_tx_data;

  uart_cmd_decoder #(.TIMEOUT_CYC(TO), .ACK_CHAR(ACK), .NAK_CHAR(NAK)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done), .tx_busy(tx_busy),
    .o_run(o_run), .o_clear(o_clear), .o_mode(o_mode), .o_set_valid(o_set_valid),
    .o_set_hour(o_set_hour), .o_set_min(o_set_min), .o_set_sec(o_set_sec),
    .o_err(o_err), .o_tx_data(o_tx_data), .o_tx_start(o_tx_start)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int err_seen = 0;
  logic [7:0] tx_q[$];
  logic [7:0] exp_tx[$];

  // Transmit requests and error pulses as seen by the outside world.
  always @(negedge clk) begin
    if (o_tx_start) tx_q.push_back(o_tx_data);
    if (o_err) err_seen++;
  end

  // Reference model: a flag for "inside a set command" and a queue of captured digits.
  bit in_set = 0;
  int digs[$];
  int eh = 0, em = 0, es = 0;

  function automatic logic [7:0] upcase(input logic [7:0] b);
    return (b >= 8'h61 && b <= 8'h7A) ? b - 8'd32 : b;
  endfunction

  // Expected pulses packed as {run, clear, mode, set_valid, err}.
  task automatic model_byte(input logic [7:0] b, output logic [4:0] e);
    logic [7:0] u;
    int h, m, s;
    e = '0;
    u = upcase(b);
    if (!in_set) begin
      if (u == "R")      begin e[4] = 1; exp_tx.push_back(ACK); end
      else if (u == "C") begin e[3] = 1; exp_tx.push_back(ACK); end
      else if (u == "M") begin e[2] = 1; exp_tx.push_back(ACK); end
      else if (u == "S") begin in_set = 1; digs.delete(); end
      else if (b == 8'h0D || b == 8'h0A || b == 8'h20) begin end
      else begin e[0] = 1; exp_tx.push_back(NAK); end
    end else if (digs.size() < 6) begin
      if (b >= 8'h30 && b <= 8'h39) digs.push_back(int'(b) - 48);
      else if (b == 8'h20) begin end
      else if (u == "S") digs.delete();
      else begin e[0] = 1; exp_tx.push_back(NAK); in_set = 0; end
    end else begin
      in_set = 0;
      h = digs[0] * 10 + digs[1];
      m = digs[2] * 10 + digs[3];
      s = digs[4] * 10 + digs[5];
      if ((b == 8'h0D || b == 8'h0A) && h <= 23 && m <= 59 && s <= 59) begin
        e[1] = 1; eh = h; em = m; es = s; exp_tx.push_back(ACK);
      end else begin
        e[0] = 1; exp_tx.push_back(NAK);
      end
    end
  endtask

  // Drive one byte, then check the pulses one cycle later and that they drop after one cycle.
  task automatic send_byte(input logic [7:0] b);
    logic [4:0] e, got;
    model_byte(b, e);
    @(negedge clk); rx_data = b; rx_done = 1'b1;
    @(negedge clk); rx_done = 1'b0; rx_data = 8'($urandom);
    got = {o_run, o_clear, o_mode, o_set_valid, o_err};
    checks++;
    if (got !== e) begin
      errors++; $display("FAIL pulses byte=%h got=%b exp=%b", b, got, e);
    end
    checks++;
    if ({o_set_hour, o_set_min, o_set_sec} !== {5'(eh), 6'(em), 6'(es)}) begin
      errors++; $display("FAIL set_value got=%0d:%0d:%0d exp=%0d:%0d:%0d",
        o_set_hour, o_set_min, o_set_sec, eh, em, es);
    end
    @(negedge clk);
    got = {o_run, o_clear, o_mode, o_set_valid, o_err};
    checks++;
    if (got !== 5'b0) begin
      errors++; $display("FAIL pulse_width byte=%h got=%b exp=00000", b, got);
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    idle(2);
    checks++;
    if ({o_run, o_clear, o_mode, o_set_valid, o_set_hour, o_set_min, o_set_sec,
         o_err, o_tx_data, o_tx_start} !== '0) begin
      errors++; $display("FAIL reset_outputs got nonzero, exp all 0");
    end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_single_cmds();
    int bad;
    tx_q.delete(); exp_tx.delete();
    send_byte("R"); idle(18);
    send_byte("c"); idle(18);
    send_byte("M"); idle(5);
    bad = (tx_q.size() != 3) ? 1 : 0;
    foreach (tx_q[i]) if (tx_q[i] !== ACK) bad = 1;
    checks++;
    if (bad) begin errors++; $display("FAIL single_cmd_tx got %0d bytes exp 3 x 4b", tx_q.size()); end
  endtask

  task automatic test_set_valid();
    tx_q.delete(); exp_tx.delete();
    send_str("S235959\r"); idle(3);
    checks++;
    if ({o_set_hour, o_set_min, o_set_sec} !== {5'd23, 6'd59, 6'd59}) begin
      errors++; $display("FAIL set_2359 got=%0d:%0d:%0d exp=23:59:59", o_set_hour, o_set_min, o_set_sec);
    end
    checks++;
    if (tx_q.size() != 1 || tx_q[0] !== ACK) begin
      errors++; $display("FAIL set_ack got %0d bytes exp one 4b", tx_q.size());
    end
  endtask

  task automatic test_set_range();
    tx_q.delete(); exp_tx.delete();
    send_str("S246000\r"); idle(3);
    checks++;
    if ({o_set_hour, o_set_min, o_set_sec} !== {5'd23, 6'd59, 6'd59}) begin
      errors++; $display("FAIL range_hold got=%0d:%0d:%0d exp=23:59:59", o_set_hour, o_set_min, o_set_sec);
    end
    checks++;
    if (tx_q.size() != 1 || tx_q[0] !== NAK) begin
      errors++; $display("FAIL range_nak got %0d bytes exp one 45", tx_q.size());
    end
  endtask

  task automatic test_timeout();
    int k, got;
    tx_q.delete(); exp_tx.delete();
    send_str("S12");
    // one cycle has already passed since the last byte was registered
    k = 1; got = 0;
    while (k < 3 * TO && got == 0) begin
      @(negedge clk); k++;
      if (o_err) got = k;
    end
    checks++;
    if (got != TO) begin errors++; $display("FAIL timeout_latency got=%0d exp=%0d", got, TO); end
    in_set = 0;
    idle(3);
    checks++;
    if (tx_q.size() != 1 || tx_q[0] !== NAK) begin
      errors++; $display("FAIL timeout_nak got %0d bytes exp one 45", tx_q.size());
    end
    send_byte("R");
  endtask

  task automatic test_busy_overwrite();
    tx_busy = 1'b1;
    idle(1);
    tx_q.delete();
    send_byte("X"); idle(5);
    send_byte("R"); idle(17);
    checks++;
    if (tx_q.size() != 0) begin errors++; $display("FAIL busy_hold got %0d starts exp 0", tx_q.size()); end
    tx_busy = 1'b0;
    idle(5);
    checks++;
    if (tx_q.size() != 1 || tx_q[0] !== ACK) begin
      errors++; $display("FAIL busy_newest got %0d bytes first=%h exp one 4b",
        tx_q.size(), (tx_q.size() > 0) ? tx_q[0] : 8'h00);
    end
    tx_q.delete(); exp_tx.delete();
  endtask

  task automatic test_reset_abort();
    int e0;
    e0 = err_seen;
    send_str("S12");
    @(negedge clk); rst = 1'b1;
    idle(2);
    checks++;
    if ({o_err, o_tx_start, o_set_hour, o_set_min, o_set_sec} !== '0) begin
      errors++; $display("FAIL abort_reset_outputs got nonzero exp 0");
    end
    rst = 1'b0;
    in_set = 0; eh = 0; em = 0; es = 0;
    tx_q.delete(); exp_tx.delete();
    idle(2);
    send_str("S010203\n"); idle(3);
    checks++;
    if (err_seen != e0) begin errors++; $display("FAIL abort_silent got %0d errs exp 0", err_seen - e0); end
    checks++;
    if ({o_set_hour, o_set_min, o_set_sec} !== {5'd1, 6'd2, 6'd3}) begin
      errors++; $display("FAIL abort_set got=%0d:%0d:%0d exp=1:2:3", o_set_hour, o_set_min, o_set_sec);
    end
    checks++;
    if (tx_q.size() != 1 || tx_q[0] !== ACK) begin
      errors++; $display("FAIL abort_ack got %0d bytes exp one 4b", tx_q.size());
    end
  endtask

  task automatic test_random();
    string alpha;
    int hh, mm, ss, bad;
    alpha = "RrCcMmSs \r\nX05A9z";
    tx_q.delete(); exp_tx.delete();
    for (int n = 0; n < 120; n++) begin
      if ($urandom_range(0, 9) < 4) begin
        hh = $urandom_range(0, 26); mm = $urandom_range(0, 62); ss = $urandom_range(0, 62);
        send_byte(($urandom_range(0, 1) != 0) ? "S" : "s");
        if ($urandom_range(0, 1) != 0) send_byte(" ");
        send_byte(8'h30 + 8'(hh / 10)); send_byte(8'h30 + 8'(hh % 10));
        send_byte(8'h30 + 8'(mm / 10)); send_byte(8'h30 + 8'(mm % 10));
        send_byte(8'h30 + 8'(ss / 10)); send_byte(8'h30 + 8'(ss % 10));
        send_byte(($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A);
      end else begin
        send_byte(alpha[$urandom_range(0, alpha.len() - 1)]);
      end
      idle($urandom_range(0, 6));
    end
    idle(5);
    bad = (tx_q.size() != exp_tx.size()) ? 1 : 0;
    if (!bad) foreach (tx_q[i]) if (tx_q[i] !== exp_tx[i]) bad = 1;
    checks++;
    if (bad) begin errors++; $display("FAIL random_tx got %0d bytes exp %0d or content differs", tx_q.size(), exp_tx.size()); end
  endtask

  initial begin
    test_reset();
    test_single_cmds();
    test_set_valid();
    test_set_range();
    test_timeout();
    test_busy_overwrite();
    test_reset_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
